aer_in_lrf_scheduler: RTL and testbench

Round-robin scheduler that shares the single AER input port of the LRF mapper between `N_SRC` upstream event sources. It:
- arbitrates between sources;
- registers the granted event;
- runs the 4-phase handshake toward the mapper;
- acknowledges the source only after the mapper completes.

It sits between the input spike sources (encoder, FIFO, host link) and the mapper's `MAP_IN_AERIN_*` port.

---
 rtl/aer_in_lrf_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_aer_in_lrf_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_in_lrf_scheduler.sv
// Round-robin arbiter feeding the LRF mapper AER input via a registered 4-phase handshake.
// Optional mapper-ACK timeout with sticky ERR is built when AER_SCHED_TIMEOUT_EN is defined.
//   state | meaning
//   IDLE  | arbitrate; grant held off while mapper ACK is still high
//   M_REQ | request asserted to mapper, waiting for ACK high
//   M_REL | request released, waiting for ACK low
//   S_ACK | acknowledge granted source, waiting for its REQ low
module aer_in_lrf_scheduler #(
  parameter int N_SRC     = 4,
  parameter int AER_WIDTH = 12,
  parameter int TIMEOUT   = 1023,
  parameter int CNT_W     = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_SRC-1:0]                     SRC_REQ,
  input  logic [N_SRC-1:0][AER_WIDTH-1:0]      SRC_EVENT,
  input  logic [N_SRC-1:0][AER_WIDTH-3:0]      SRC_IDX,
  output logic [N_SRC-1:0]                     SRC_ACK,
  output logic                                 MAP_IN_AERIN_REQ,
  output logic [AER_WIDTH-1:0]                 MAP_IN_AERIN_EVENT,
  output logic [AER_WIDTH-3:0]                 MAP_IN_AERIN_IDX,
  input  logic                                 MAP_IN_AERIN_ACK,
  output logic [$clog2(N_SRC)-1:0]             GRANT_ID,
  output logic                                 BUSY,
  output logic [CNT_W-1:0]                     EVT_CNT,
  input  logic                                 ERR_CLR,
  output logic                                 ERR
);

  localparam int GW    = $clog2(N_SRC);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, M_REQ, M_REL, S_ACK} state_t;

  state_t                 state_q, state_d;
  logic                   req_q, req_d;
  logic [N_SRC-1:0]       ack_q, ack_d;
  logic [AER_WIDTH-1:0]   event_q, event_d;
  logic [AER_WIDTH-3:0]   idx_q, idx_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [GW-1:0]          last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   win_found;
  logic [GW-1:0]          win_id;
  logic [GW-1:0]          cand;
  logic                   tmo_hit;

  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] v);
    return (v == GW'(N_SRC - 1)) ? '0 : v + 1'b1;
  endfunction

`ifdef AER_SCHED_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             tmo_tc;
  assign tmo_tc = (tmo_q == '0);
`endif

  // Rotating-priority search starting one past the last completed grant.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = wrap_inc(last_q);
    for (int i = 0; i < N_SRC; i++) begin
      if (!win_found && SRC_REQ[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    ack_d   = ack_q;
    event_d = event_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmo_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found && !MAP_IN_AERIN_ACK) begin
          state_d = M_REQ;
          req_d   = 1'b1;
          event_d = SRC_EVENT[win_id];
          idx_d   = SRC_IDX[win_id];
          grant_d = win_id;
        end
      end
      M_REQ: begin
        if (MAP_IN_AERIN_ACK) begin
          state_d = M_REL;
          req_d   = 1'b0;
        end
`ifdef AER_SCHED_TIMEOUT_EN
        else if (tmo_tc) begin
          tmo_hit = 1'b1;
        end
`endif
      end
      M_REL: begin
        if (!MAP_IN_AERIN_ACK) begin
          state_d        = S_ACK;
          cnt_d          = cnt_q + 1'b1;
          ack_d          = '0;
          ack_d[grant_q] = 1'b1;
        end
`ifdef AER_SCHED_TIMEOUT_EN
        else if (tmo_tc) begin
          tmo_hit = 1'b1;
        end
`endif
      end
      S_ACK: begin
        if (!SRC_REQ[grant_q]) begin
          state_d = IDLE;
          ack_d   = '0;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // A timed-out transfer still releases the source but is not counted.
    if (tmo_hit) begin
      state_d        = S_ACK;
      req_d          = 1'b0;
      ack_d          = '0;
      ack_d[grant_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      ack_q   <= '0;
      event_q <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      last_q  <= GW'(N_SRC - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      event_q <= event_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef AER_SCHED_TIMEOUT_EN
  // Down-counter reloads on every state change, so each wait phase gets a full budget.
  always_comb begin
    tmo_d = (state_d != state_q) ? TMO_W'(TIMEOUT - 1) : tmo_q - 1'b1;
    err_d = ERR_CLR ? 1'b0 : err_q;
    if (tmo_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= TMO_W'(TIMEOUT - 1);
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{ERR_CLR, TMO_W'(TIMEOUT)};
  assign ERR        = 1'b0;
`endif

  assign SRC_ACK            = ack_q;
  assign MAP_IN_AERIN_REQ   = req_q;
  assign MAP_IN_AERIN_EVENT = event_q;
  assign MAP_IN_AERIN_IDX   = idx_q;
  assign GRANT_ID           = grant_q;
  assign BUSY               = (state_q != IDLE);
  assign EVT_CNT            = cnt_q;

endmodule

// File: tb/tb_aer_in_lrf_scheduler.sv
// Randomized and directed bench for aer_in_lrf_scheduler against a round-robin reference model.
module tb_aer_in_lrf_scheduler;
  localparam int N = 4;
  localparam int W = 12;
`ifdef AER_SCHED_TIMEOUT_EN
  localparam int TMO = 15;
`else
  localparam int TMO = 1023;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N-1:0]          src_req = '0;
  logic [N-1:0][W-1:0]   src_event = '0;
  logic [N-1:0][W-3:0]   src_idx = '0;
  logic [N-1:0]          SRC_ACK;
  logic                  MAP_IN_AERIN_REQ;
  logic [W-1:0]          MAP_IN_AERIN_EVENT;
  logic [W-3:0]          MAP_IN_AERIN_IDX;
  logic                  map_ack = 1'b0;
  logic [1:0]            GRANT_ID;
  logic                  BUSY;
  logic [15:0]           EVT_CNT;
  logic                  err_clr = 1'b0;
  logic                  ERR;

  int         errors = 0;
  int         checks = 0;
  int         ptr;            // model: last granted source
  logic [15:0] exp_cnt;       // model: completed transfers
  int         gq[$];          // grants observed during traffic

  aer_in_lrf_scheduler #(.N_SRC(N), .AER_WIDTH(W), .TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .SRC_REQ(src_req), .SRC_EVENT(src_event), .SRC_IDX(src_idx),
    .SRC_ACK(SRC_ACK), .MAP_IN_AERIN_REQ(MAP_IN_AERIN_REQ), .MAP_IN_AERIN_EVENT(MAP_IN_AERIN_EVENT),
    .MAP_IN_AERIN_IDX(MAP_IN_AERIN_IDX), .MAP_IN_AERIN_ACK(map_ack), .GRANT_ID(GRANT_ID),
    .BUSY(BUSY), .EVT_CNT(EVT_CNT), .ERR_CLR(err_clr), .ERR(ERR)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; src_req = '0; map_ack = 1'b0; err_clr = 1'b0;
    tick; tick;
    checks++;
    if ({SRC_ACK, MAP_IN_AERIN_REQ, MAP_IN_AERIN_EVENT, MAP_IN_AERIN_IDX, GRANT_ID, BUSY, EVT_CNT, ERR} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ack=%b req=%b ev=%h idx=%h gid=%0d busy=%b cnt=%h err=%b required all zero",
               SRC_ACK, MAP_IN_AERIN_REQ, MAP_IN_AERIN_EVENT, MAP_IN_AERIN_IDX, GRANT_ID, BUSY, EVT_CNT, ERR);
    end
    rst = 1'b0;
    ptr = N - 1;
    exp_cnt = '0;
    tick;
    checks++;
    if (BUSY !== 1'b0 || MAP_IN_AERIN_REQ !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b req=%b required 0/0", BUSY, MAP_IN_AERIN_REQ);
    end
  endtask

  task automatic test_single;
    src_event[0] = 12'h00A; src_idx[0] = 10'h005; src_req[0] = 1'b1;
    tick;  // cycle t sampled
    checks++;
    if (MAP_IN_AERIN_REQ !== 1'b1 || MAP_IN_AERIN_EVENT !== 12'h00A || MAP_IN_AERIN_IDX !== 10'h005 || GRANT_ID !== 2'd0) begin
      errors++;
      $display("FAIL single_t1 req=%b ev=%h idx=%h gid=%0d required 1/00a/005/0",
               MAP_IN_AERIN_REQ, MAP_IN_AERIN_EVENT, MAP_IN_AERIN_IDX, GRANT_ID);
    end
    map_ack = 1'b1;
    tick;
    checks++;
    if (MAP_IN_AERIN_REQ !== 1'b0 || SRC_ACK !== 4'b0000) begin
      errors++;
      $display("FAIL single_t2 req=%b ack=%b required 0/0000", MAP_IN_AERIN_REQ, SRC_ACK);
    end
    map_ack = 1'b0;
    tick;
    checks++;
    if (SRC_ACK !== 4'b0001 || EVT_CNT !== 16'd1) begin
      errors++;
      $display("FAIL single_t3 ack=%b cnt=%0d required 0001/1", SRC_ACK, EVT_CNT);
    end
    src_req[0] = 1'b0;
    tick;
    checks++;
    if (SRC_ACK !== 4'b0000 || BUSY !== 1'b0 || MAP_IN_AERIN_EVENT !== 12'h00A) begin
      errors++;
      $display("FAIL single_t4 ack=%b busy=%b ev=%h required 0000/0/00a", SRC_ACK, BUSY, MAP_IN_AERIN_EVENT);
    end
    ptr = 0;
    exp_cnt = 16'd1;
  endtask

  task automatic finish_xfer;
    int n;
    map_ack = 1'b1; tick; map_ack = 1'b0;
    n = 0;
    while (SRC_ACK == '0 && n < 20) begin tick; n++; end
    checks++;
    if (SRC_ACK == '0) begin
      errors++;
      $display("FAIL finish_timeout src_ack=%b required nonzero", SRC_ACK);
    end
    src_req = '0;
    tick;
  endtask

  task automatic test_reset_mid;
    src_event[0] = 12'($urandom); src_idx[0] = 10'($urandom);
    src_event[1] = 12'($urandom); src_idx[1] = 10'($urandom);
    src_req = 4'b0011;
    tick;
    checks++;
    if (MAP_IN_AERIN_REQ !== 1'b1 || GRANT_ID !== 2'd1 || MAP_IN_AERIN_EVENT !== src_event[1]) begin
      errors++;
      $display("FAIL midrst_pre req=%b gid=%0d ev=%h required 1/1/%h", MAP_IN_AERIN_REQ, GRANT_ID, MAP_IN_AERIN_EVENT, src_event[1]);
    end
    map_ack = 1'b1; rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({SRC_ACK, MAP_IN_AERIN_REQ, MAP_IN_AERIN_EVENT, MAP_IN_AERIN_IDX, GRANT_ID, BUSY, EVT_CNT} !== '0) begin
      errors++;
      $display("FAIL midrst_zero req=%b ev=%h gid=%0d busy=%b cnt=%0d required all zero",
               MAP_IN_AERIN_REQ, MAP_IN_AERIN_EVENT, GRANT_ID, BUSY, EVT_CNT);
    end
    ptr = N - 1; exp_cnt = '0;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++;
      if (MAP_IN_AERIN_REQ !== 1'b0 || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL midrst_holdoff cyc=%0d req=%b busy=%b required 0/0", c, MAP_IN_AERIN_REQ, BUSY);
      end
    end
    map_ack = 1'b0;
    tick;
    checks++;
    if (MAP_IN_AERIN_REQ !== 1'b1 || GRANT_ID !== 2'd0 || MAP_IN_AERIN_EVENT !== src_event[0]) begin
      errors++;
      $display("FAIL midrst_regrant req=%b gid=%0d ev=%h required 1/0/%h", MAP_IN_AERIN_REQ, GRANT_ID, MAP_IN_AERIN_EVENT, src_event[0]);
    end
    finish_xfer();
    ptr = 0; exp_cnt = 16'd1;
  endtask

  task automatic test_delayed_ack;
    logic [W-1:0] e;
    logic [W-3:0] ix;
    int nreq, bad;
    e = 12'($urandom); ix = 10'($urandom);
    src_event[2] = e; src_idx[2] = ix; src_req[2] = 1'b1;
    tick;
    nreq = 0; bad = 0;
    while (MAP_IN_AERIN_REQ && nreq < 20) begin
      nreq++;
      if (MAP_IN_AERIN_EVENT !== e || MAP_IN_AERIN_IDX !== ix) bad++;
      if (nreq == 8) map_ack = 1'b1;
      tick;
    end
    checks++;
    if (nreq != 8 || bad != 0) begin
      errors++;
      $display("FAIL delay_req_len cycles=%0d unstable=%0d required 8/0", nreq, bad);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (SRC_ACK !== 4'b0000) begin
        errors++;
        $display("FAIL delay_early_ack cyc=%0d ack=%b required 0000", c, SRC_ACK);
      end
      tick;
    end
    map_ack = 1'b0;
    tick;
    exp_cnt++;
    checks++;
    if (SRC_ACK !== 4'b0100 || EVT_CNT !== exp_cnt || MAP_IN_AERIN_EVENT !== e) begin
      errors++;
      $display("FAIL delay_src_ack ack=%b cnt=%0d ev=%h required 0100/%0d/%h", SRC_ACK, EVT_CNT, MAP_IN_AERIN_EVENT, exp_cnt, e);
    end
    src_req[2] = 1'b0;
    tick;
    ptr = 2;
  endtask

  // Randomized sources and mapper; every grant and completion is checked against the model.
  task automatic traffic(input int n, input int maxd, input int pct);
    int done, cyc, md, exp_g, c;
    logic req_prev, ack_prev;
    logic [W-1:0] lat_e;
    logic [W-3:0] lat_i;
    done = 0; cyc = 0; md = 0; req_prev = 1'b0; ack_prev = 1'b0; lat_e = '0; lat_i = '0;
    while (cyc < 4000 && !(done >= n && src_req == '0 && !BUSY && !map_ack)) begin
      if (MAP_IN_AERIN_REQ && !req_prev) begin
        exp_g = -1;
        for (int k = 1; k <= N; k++) begin
          c = (ptr + k) % N;
          if (exp_g < 0 && src_req[c]) exp_g = c;
        end
        checks++;
        if (exp_g < 0 || int'(GRANT_ID) != exp_g || MAP_IN_AERIN_EVENT !== src_event[exp_g] ||
            MAP_IN_AERIN_IDX !== src_idx[exp_g]) begin
          errors++;
          $display("FAIL rr_grant gid=%0d ev=%h idx=%h required gid=%0d", GRANT_ID, MAP_IN_AERIN_EVENT, MAP_IN_AERIN_IDX, exp_g);
        end
        if (exp_g >= 0) begin
          lat_e = src_event[exp_g]; lat_i = src_idx[exp_g]; ptr = exp_g;
        end
        gq.push_back(int'(GRANT_ID));
      end else if (MAP_IN_AERIN_REQ) begin
        checks++;
        if (MAP_IN_AERIN_EVENT !== lat_e || MAP_IN_AERIN_IDX !== lat_i) begin
          errors++;
          $display("FAIL hold_stable ev=%h idx=%h required %h/%h", MAP_IN_AERIN_EVENT, MAP_IN_AERIN_IDX, lat_e, lat_i);
        end
      end
      if (SRC_ACK != '0 && !ack_prev) begin
        exp_cnt++;
        done++;
        checks++;
        if (SRC_ACK !== (4'b0001 << ptr) || EVT_CNT !== exp_cnt) begin
          errors++;
          $display("FAIL src_ack ack=%b cnt=%0d required %b/%0d", SRC_ACK, EVT_CNT, 4'b0001 << ptr, exp_cnt);
        end
      end
      req_prev = MAP_IN_AERIN_REQ;
      ack_prev = |SRC_ACK;
      if (MAP_IN_AERIN_REQ != map_ack) begin
        if (md == 0) begin
          map_ack = MAP_IN_AERIN_REQ;
          md = $urandom_range(0, maxd);
        end else md--;
      end
      for (int i = 0; i < N; i++) begin
        if (src_req[i] && SRC_ACK[i]) src_req[i] = 1'b0;
        else if (!src_req[i] && !SRC_ACK[i] && done < n && $urandom_range(1, 100) <= pct) begin
          src_event[i] = 12'($urandom); src_idx[i] = 10'($urandom); src_req[i] = 1'b1;
        end
      end
      tick;
      cyc++;
    end
    checks++;
    if (done < n || BUSY) begin
      errors++;
      $display("FAIL traffic_timeout done=%0d busy=%b required %0d/0", done, BUSY, n);
    end
  endtask

  task automatic test_round_robin;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    test_reset();
    gq.delete();
    traffic(8, 0, 100);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= gq.size() || gq[i] != exp_seq[i]) begin
        errors++;
        $display("FAIL rr_order pos=%0d got=%0d required %0d", i, (i < gq.size()) ? gq[i] : -1, exp_seq[i]);
      end
    end
  endtask

  task automatic test_random;
    traffic(60, 3, 40);
  endtask

  task automatic test_wrap;
    force dut.cnt_q = 16'hFFFF;
    tick;
    release dut.cnt_q;
    tick;
    checks++;
    if (EVT_CNT !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload cnt=%h required ffff", EVT_CNT);
    end
    exp_cnt = 16'hFFFF;
    src_event[3] = 12'h801; src_idx[3] = 10'h3FF; src_req[3] = 1'b1;  // config-type event forwarded as-is
    traffic(1, 0, 0);
    checks++;
    if (EVT_CNT !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_cnt cnt=%h required 0000", EVT_CNT);
    end
  endtask

`ifdef AER_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    int nreq;
    logic [15:0] cnt0;
    cnt0 = EVT_CNT;
    src_event[1] = 12'($urandom); src_req[1] = 1'b1;
    tick;
    nreq = 0;
    while (MAP_IN_AERIN_REQ && nreq < 40) begin nreq++; tick; end
    checks++;
    if (nreq != 15 || ERR !== 1'b1 || SRC_ACK !== 4'b0010 || EVT_CNT !== cnt0) begin
      errors++;
      $display("FAIL timeout cycles=%0d err=%b ack=%b cnt=%0d required 15/1/0010/%0d", nreq, ERR, SRC_ACK, EVT_CNT, cnt0);
    end
    src_req[1] = 1'b0;
    tick;
    checks++;
    if (ERR !== 1'b1) begin errors++; $display("FAIL err_sticky err=%b required 1", ERR); end
    err_clr = 1'b1; tick; err_clr = 1'b0;
    checks++;
    if (ERR !== 1'b0) begin errors++; $display("FAIL err_clr err=%b required 0", ERR); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_reset_mid();
    test_delayed_ack();
    test_round_robin();
    test_random();
    test_wrap();
`ifdef AER_SCHED_TIMEOUT_EN
    test_reset();
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
